// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: video scanout reads have absolute priority, the CPU bus
// takes the free slots. One registered memory command per clock_50 cycle.
module vram_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 24,
    parameter int unsigned CPU_W  = 8
) (
    input  logic              clock_50,
    input  logic              reset,
    input  logic              vid_req_i,
    input  logic [ADDR_W-1:0] vid_adr_i,
    output logic [DATA_W-1:0] vid_d_o,
    output logic              vid_valid_o,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_adr_i,
    input  logic [CPU_W-1:0]  cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [CPU_W-1:0]  cpu_rdata_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [7:0]        stall_max_o,
    input  logic              stat_clr_i
);

    typedef enum logic [1:0] {StIdle, StRd1, StRd2, StAckW} cpu_state_e;

    cpu_state_e        state_q;
    logic [ADDR_W-1:0] mem_adr_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              vtag1_q, vtag2_q;
    logic              vid_valid_q;
    logic [DATA_W-1:0] vid_d_q;
    logic              cpu_ack_q;
    logic [CPU_W-1:0]  cpu_rdata_q;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic [7:0]        stall_max_q, stall_max_d;
    logic              cpu_idle;
    logic              cpu_grant;

    assign cpu_idle  = (state_q == StIdle);
    assign cpu_grant = !vid_req_i && cpu_req_i && cpu_idle;

    // Counter saturates at 255, so stall_max inherits the same ceiling.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (cpu_grant) begin
            wait_cnt_d = 8'd0;
        end else if (cpu_req_i && cpu_idle && vid_req_i && (wait_cnt_q != 8'hFF)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
        if (stat_clr_i) begin
            stall_max_d = 8'd0;
        end else begin
            stall_max_d = (wait_cnt_d > stall_max_q) ? wait_cnt_d : stall_max_q;
        end
    end

    always_ff @(posedge clock_50) begin
        if (!reset) begin
            state_q     <= StIdle;
            mem_adr_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            vtag1_q     <= 1'b0;
            vtag2_q     <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_d_q     <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            wait_cnt_q  <= 8'd0;
            stall_max_q <= 8'd0;
        end else begin
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            vtag1_q     <= 1'b0;
            vtag2_q     <= vtag1_q;
            vid_valid_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
            wait_cnt_q  <= wait_cnt_d;
            stall_max_q <= stall_max_d;

            // vtag2 marks that mem_rdata now holds the word a video command asked for.
            if (vtag2_q) begin
                vid_valid_q <= 1'b1;
                vid_d_q     <= mem_rdata_i;
            end

            if (vid_req_i) begin
                mem_adr_q <= vid_adr_i;
                vtag1_q   <= 1'b1;
            end else if (cpu_grant) begin
                mem_adr_q   <= cpu_adr_i;
                mem_we_q    <= cpu_we_i;
                mem_wdata_q <= DATA_W'(cpu_wdata_i);
            end

            unique case (state_q)
                StIdle: begin
                    if (cpu_grant) begin
                        state_q <= cpu_we_i ? StAckW : StRd1;
                    end
                end
                StRd1: state_q <= StRd2;
                StRd2: begin
                    state_q     <= StIdle;
                    cpu_ack_q   <= 1'b1;
                    cpu_rdata_q <= mem_rdata_i[CPU_W-1:0];
                end
                StAckW: begin
                    state_q   <= StIdle;
                    cpu_ack_q <= 1'b1;
                end
            endcase
        end
    end

    assign mem_adr_o   = mem_adr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_wdata_q;
    assign vid_d_o     = vid_d_q;
    assign vid_valid_o = vid_valid_q;
    assign cpu_ack_o   = cpu_ack_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign stall_max_o = stall_max_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios followed by random traffic, checked against a
// transaction-level model of slot arbitration, read latency and CPU wait accounting.
module tb_vram_arbiter;

    logic        clock_50 = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [15:0] vid_adr;
    logic [23:0] vid_d;
    logic        vid_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_adr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_adr;
    logic        mem_we;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata;
    logic [7:0]  stall_max;
    logic        stat_clr;

    always #10 clock_50 = ~clock_50;

    vram_arbiter dut (
        .clock_50    (clock_50),
        .reset       (reset),
        .vid_req_i   (vid_req),
        .vid_adr_i   (vid_adr),
        .vid_d_o     (vid_d),
        .vid_valid_o (vid_valid),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_adr_i   (cpu_adr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_ack_o   (cpu_ack),
        .cpu_rdata_o (cpu_rdata),
        .mem_adr_o   (mem_adr),
        .mem_we_o    (mem_we),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .stall_max_o (stall_max),
        .stat_clr_i  (stat_clr)
    );

    // Synchronous-read RAM; default contents word = adr*3, loaded on the first edge.
    logic [23:0] ram [65536];
    bit          ram_ready = 1'b0;
    logic        pl_en = 1'b0;
    logic [15:0] pl_adr = 16'h0;
    logic [23:0] pl_dat = 24'h0;

    always @(posedge clock_50) begin
        if (!ram_ready) begin
            for (int a = 0; a < 65536; a++) ram[a] <= 24'(a * 3);
            ram_ready <= 1'b1;
        end else begin
            if (pl_en) ram[pl_adr] <= pl_dat;
            if (mem_we) ram[mem_adr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_adr];
    end

    // Reference model state
    logic [23:0] model_mem [65536];
    int          cyc = 0;
    int          vq_due[$];
    logic [23:0] vq_dat[$];
    int          ack_due = -1;
    int          busy_until = 0;
    bit          ack_rd;
    logic [7:0]  ack_dat;
    int          wait_m = 0;
    int          stall_m = 0;

    bit          exp_vv, exp_ack, exp_ack_rd, exp_we, exp_adr_chk;
    logic [23:0] exp_vd, exp_wdata;
    logic [7:0]  exp_rdata;
    logic [15:0] exp_adr;

    int total = 0;
    int bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Applies the arbitration rules to the inputs sampled at this edge.
    task automatic model_edge();
        cyc++;
        exp_vv = 0; exp_ack = 0; exp_we = 0; exp_adr_chk = 0;
        if (!reset) begin
            vq_due.delete();
            vq_dat.delete();
            ack_due = -1;
            busy_until = cyc;
            wait_m = 0;
            stall_m = 0;
            exp_adr_chk = 1;
            exp_adr = 16'h0;
            return;
        end
        if (vq_due.size() > 0 && vq_due[0] == cyc) begin
            exp_vv = 1;
            exp_vd = vq_dat.pop_front();
            void'(vq_due.pop_front());
        end
        if (ack_due == cyc) begin
            exp_ack = 1;
            exp_ack_rd = ack_rd;
            exp_rdata = ack_dat;
        end
        if (vid_req) begin
            vq_due.push_back(cyc + 2);
            vq_dat.push_back(model_mem[vid_adr]);
            exp_adr_chk = 1;
            exp_adr = vid_adr;
            if (cpu_req && cyc > busy_until && wait_m < 255) wait_m++;
        end else if (cpu_req && cyc > busy_until) begin
            exp_adr_chk = 1;
            exp_adr = cpu_adr;
            wait_m = 0;
            if (cpu_we) begin
                exp_we = 1;
                exp_wdata = {16'h0, cpu_wdata};
                model_mem[cpu_adr] = {16'h0, cpu_wdata};
                ack_due = cyc + 1;
                ack_rd = 0;
                busy_until = cyc + 1;
            end else begin
                ack_due = cyc + 2;
                ack_rd = 1;
                ack_dat = model_mem[cpu_adr][7:0];
                busy_until = cyc + 2;
            end
        end
        if (stat_clr) stall_m = 0;
        else if (wait_m > stall_m) stall_m = wait_m;
    endtask

    task automatic check_outputs();
        check_eq("vid_valid", 32'(vid_valid), 32'(exp_vv));
        if (exp_vv) check_eq("vid_d", 32'(vid_d), 32'(exp_vd));
        check_eq("cpu_ack", 32'(cpu_ack), 32'(exp_ack));
        if (exp_ack && exp_ack_rd) check_eq("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata));
        check_eq("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_we) check_eq("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
        if (exp_adr_chk) check_eq("mem_adr", 32'(mem_adr), 32'(exp_adr));
        check_eq("stall_max", 32'(stall_max), 32'(stall_m));
    endtask

    // One clock: model the edge, check at the falling edge, requester drops on ack.
    task automatic cycle();
        @(posedge clock_50);
        model_edge();
        @(negedge clock_50);
        check_outputs();
        if (exp_ack) cpu_req = 1'b0;
    endtask

    task automatic idle(input int n);
        vid_req = 1'b0;
        stat_clr = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic cpu_start(input bit we, input logic [15:0] adr, input logic [7:0] wd);
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_adr = adr;
        cpu_wdata = wd;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) model_mem[a] = 24'(a * 3);
        reset = 1'b0; vid_req = 1'b1; vid_adr = 16'h0100; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_adr = 16'h0; cpu_wdata = 8'h0; stat_clr = 1'b0;

        // Reset held with a video request pending
        for (int i = 0; i < 3; i++) cycle();

        // Video stream 0x0100..0x0107 straight out of reset
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vid_req = 1'b1;
            vid_adr = 16'h0100 + 16'(i);
            cycle();
        end
        idle(4);

        // Alternating slots with a CPU write
        cpu_start(1'b1, 16'h1234, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            vid_req = (i % 2 == 0);
            vid_adr = 16'h0200 + 16'(i);
            cycle();
        end
        idle(4);

        // CPU read of a preloaded word while video reads are pipelined
        pl_en = 1'b1; pl_adr = 16'h0042; pl_dat = 24'hFFEE11;
        model_mem[16'h0042] = 24'hFFEE11;
        cycle();
        pl_en = 1'b0;
        cpu_start(1'b0, 16'h0042, 8'h00);
        for (int i = 0; i < 8; i++) begin
            vid_req = (i != 2);
            vid_adr = 16'h0300 + 16'(i);
            cycle();
        end
        idle(4);

        // Starvation: ten video cycles in front of a CPU read
        stat_clr = 1'b1;
        cycle();
        stat_clr = 1'b0;
        cpu_start(1'b0, 16'h0042, 8'h00);
        for (int i = 0; i < 10; i++) begin
            vid_req = 1'b1;
            vid_adr = 16'h0400 + 16'(i);
            cycle();
        end
        idle(5);
        check_eq("stall_after_starve", 32'(stall_max), 32'd10);
        stat_clr = 1'b1;
        cycle();
        stat_clr = 1'b0;
        check_eq("stall_cleared", 32'(stall_max), 32'd0);

        // Reset while the CPU read is in RD1
        cpu_start(1'b0, 16'h0042, 8'h00);
        cycle();
        reset = 1'b0;
        cpu_req = 1'b0;
        cycle();
        reset = 1'b1;
        idle(4);
        cpu_start(1'b0, 16'h0042, 8'h00);
        idle(5);

        // Random traffic over a small address window so reads and writes collide
        for (int i = 0; i < 3000; i++) begin
            vid_req = ($urandom_range(0, 9) < 6);
            vid_adr = 16'($urandom_range(0, 63));
            if (!cpu_req && $urandom_range(0, 3) == 0)
                cpu_start(1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 8'($urandom));
            stat_clr = ($urandom_range(0, 49) == 0);
            reset = !($urandom_range(0, 199) == 0);
            if (!reset) cpu_req = 1'b0;
            cycle();
        end
        reset = 1'b1;
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
